// File: rtl/snoopy_line_lock.sv
// Line-granular lock between one CPU controller and N snoop channels.
// Define LOCK_STATS_EN to add the saturating conflictCount statistic.
`timescale 1ns/1ps
module snoopy_line_lock #(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int OFFSET_WIDTH    = 4,
  parameter int NUM_SNOOP_PORTS = 2
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       cpuRequest,
  input  logic [ADDRESS_WIDTH-1:0]                   cpuAddress,
  input  logic                                       cpuDone,
  output logic                                       cpuGrant,
  input  logic [NUM_SNOOP_PORTS-1:0]                 snoopRequest,
  input  logic [NUM_SNOOP_PORTS*ADDRESS_WIDTH-1:0]   snoopAddress,
  input  logic [NUM_SNOOP_PORTS-1:0]                 snoopDone,
`ifdef LOCK_STATS_EN
  output logic [15:0]                                conflictCount,
`endif
  output logic [NUM_SNOOP_PORTS-1:0]                 snoopGrant
);

  localparam int NP = NUM_SNOOP_PORTS;
  localparam int LW = ADDRESS_WIDTH - OFFSET_WIDTH;
  localparam int IW = (NP > 1) ? $clog2(NP) : 1;

  typedef logic [LW-1:0] line_t;
  typedef enum logic [1:0] {CPU_IDLE, CPU_WAIT, CPU_OWN} cpuState_t;
  typedef enum logic {SN_IDLE, SN_OWN} snoopState_t;

  cpuState_t   cpuState;
  snoopState_t snoopState;
  line_t       cpuLineQ;
  line_t       ownerLine;
  logic [IW-1:0] ownerIdx;
  logic [IW-1:0] rrPtr;

  line_t   cpuLine;
  line_t   snoopLine [NP];
  logic [NP-1:0] snoopBlocked;
  logic [NP-1:0] eligible;
  logic    cpuHolds;
  logic    pickValid;
  logic [IW-1:0] pickIdx;
  line_t   pickLine;
  logic    snoopOwnsCpuLine;
  logic    snoopTakesCpuLine;
  logic    cpuMayOwn;
  logic    unusedOffsets;

  assign unusedOffsets = ^{cpuAddress, snoopAddress};
  assign cpuLine = cpuAddress[ADDRESS_WIDTH-1:OFFSET_WIDTH];
  // A CPU releasing this edge no longer blocks a snoop on its line.
  assign cpuHolds = (cpuState == CPU_OWN) && !cpuDone;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      snoopLine[i] = snoopAddress[i*ADDRESS_WIDTH+OFFSET_WIDTH +: LW];
      snoopBlocked[i] = snoopRequest[i] && cpuHolds
                        && (snoopLine[i] == cpuLineQ);
    end
  end

  assign eligible = snoopRequest & ~snoopBlocked;

  // Round-robin: first eligible channel at or after rrPtr.
  always_comb begin
    int k;
    k = 0;
    pickValid = 1'b0;
    pickIdx = '0;
    pickLine = '0;
    for (int j = 0; j < NP; j++) begin
      k = (int'(rrPtr) + j) % NP;
      if (!pickValid && eligible[k]) begin
        pickValid = 1'b1;
        pickIdx = IW'(k);
        pickLine = snoopLine[k];
      end
    end
  end

  assign snoopOwnsCpuLine = (snoopState == SN_OWN)
                            && (ownerLine == cpuLineQ);
  assign snoopTakesCpuLine = (snoopState == SN_IDLE) && pickValid
                             && (pickLine == cpuLineQ);
  assign cpuMayOwn = !snoopOwnsCpuLine && !snoopTakesCpuLine;

  always_ff @(posedge clock) begin
    if (reset) begin
      cpuState <= CPU_IDLE;
      cpuGrant <= 1'b0;
      cpuLineQ <= '0;
    end else begin
      unique case (cpuState)
        CPU_IDLE: begin
          if (cpuRequest) begin
            cpuState <= CPU_WAIT;
            cpuLineQ <= cpuLine;
          end
        end
        CPU_WAIT: begin
          if (!cpuRequest) begin
            cpuState <= CPU_IDLE;
          end else if (cpuMayOwn) begin
            cpuState <= CPU_OWN;
            cpuGrant <= 1'b1;
          end
        end
        CPU_OWN: begin
          if (cpuDone) begin
            cpuState <= CPU_IDLE;
            cpuGrant <= 1'b0;
          end
        end
        default: begin
          cpuState <= CPU_IDLE;
          cpuGrant <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snoopState <= SN_IDLE;
      snoopGrant <= '0;
      ownerIdx <= '0;
      ownerLine <= '0;
      rrPtr <= '0;
    end else begin
      unique case (snoopState)
        SN_IDLE: begin
          if (pickValid) begin
            snoopState <= SN_OWN;
            snoopGrant <= NP'(1) << pickIdx;
            ownerIdx <= pickIdx;
            ownerLine <= pickLine;
          end
        end
        SN_OWN: begin
          if (snoopDone[ownerIdx]) begin
            snoopState <= SN_IDLE;
            snoopGrant <= '0;
            rrPtr <= (ownerIdx == IW'(NP-1)) ? '0 : ownerIdx + 1'b1;
          end
        end
        default: begin
          snoopState <= SN_IDLE;
          snoopGrant <= '0;
        end
      endcase
    end
  end

`ifdef LOCK_STATS_EN
  logic cpuBlocked;
  logic anyBlocked;

  assign cpuBlocked = (cpuState == CPU_WAIT) && cpuRequest && !cpuMayOwn;
  assign anyBlocked = cpuBlocked || |(snoopBlocked & ~snoopGrant);

  always_ff @(posedge clock) begin
    if (reset) begin
      conflictCount <= '0;
    end else if (anyBlocked && conflictCount != 16'hFFFF) begin
      conflictCount <= conflictCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snoopy_line_lock.sv
// Bench for snoopy_line_lock: directed steps, then random traffic
// checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_snoopy_line_lock;

  localparam int AW = 16;
  localparam int NP = 2;

  logic clock = 1'b0;
  logic reset;
  logic cpuRequest;
  logic [AW-1:0] cpuAddress;
  logic cpuDone;
  logic cpuGrant;
  logic [NP-1:0] snoopRequest;
  logic [NP*AW-1:0] snoopAddress;
  logic [NP-1:0] snoopDone;
  logic [NP-1:0] snoopGrant;
`ifdef LOCK_STATS_EN
  logic [15:0] conflictCount;
`endif

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int mCpu;
  logic [11:0] mCpuLine;
  int mOwner;
  logic [11:0] mOwnerLine;
  int mRr;
  int mCount;
  logic mCpuGrant;
  logic [NP-1:0] mSnoopGrant;

  snoopy_line_lock #(
    .ADDRESS_WIDTH(AW),
    .OFFSET_WIDTH(4),
    .NUM_SNOOP_PORTS(NP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpuRequest(cpuRequest),
    .cpuAddress(cpuAddress),
    .cpuDone(cpuDone),
    .cpuGrant(cpuGrant),
    .snoopRequest(snoopRequest),
    .snoopAddress(snoopAddress),
    .snoopDone(snoopDone),
`ifdef LOCK_STATS_EN
    .conflictCount(conflictCount),
`endif
    .snoopGrant(snoopGrant)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] sLine(int i);
    logic [AW-1:0] a;
    a = snoopAddress[i*AW +: AW];
    return a[15:4];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int pick;
    int c;
    bit allowed;
    bit anyBlk;
    bit blk [NP];
    if (reset) begin
      mCpu = 0; mCpuLine = '0; mOwner = -1;
      mOwnerLine = '0; mRr = 0; mCount = 0;
    end else begin
      pick = -1;
      anyBlk = 0;
      for (int i = 0; i < NP; i++) begin
        blk[i] = snoopRequest[i] && mCpu == 2 && !cpuDone
                 && sLine(i) == mCpuLine;
        if (blk[i] && i != mOwner) anyBlk = 1;
      end
      if (mOwner < 0) begin
        for (int j = 0; j < NP; j++) begin
          c = (mRr + j) % NP;
          if (pick < 0 && snoopRequest[c] && !blk[c]) pick = c;
        end
      end
      allowed = !(mOwner >= 0 && mOwnerLine == mCpuLine)
                && !(pick >= 0 && sLine(pick) == mCpuLine);
      if (mCpu == 1 && cpuRequest && !allowed) anyBlk = 1;
      if (anyBlk && mCount < 65535) mCount++;
      case (mCpu)
        0: if (cpuRequest) begin mCpu = 1; mCpuLine = cpuAddress[15:4]; end
        1: if (!cpuRequest) mCpu = 0; else if (allowed) mCpu = 2;
        default: if (cpuDone) mCpu = 0;
      endcase
      if (pick >= 0) begin
        mOwner = pick;
        mOwnerLine = sLine(pick);
      end else if (mOwner >= 0 && snoopDone[mOwner]) begin
        mRr = (mOwner + 1) % NP;
        mOwner = -1;
      end
    end
    mCpuGrant = (mCpu == 2);
    mSnoopGrant = (mOwner >= 0) ? NP'(1 << mOwner) : '0;
  endtask

  task automatic step();
    @(posedge clock);
    modelStep();
    #1;
    check("cpuGrant", 32'(cpuGrant), 32'(mCpuGrant));
    check("snoopGrant", 32'(snoopGrant), 32'(mSnoopGrant));
`ifdef LOCK_STATS_EN
    check("conflictCount", 32'(conflictCount), 32'(mCount));
`endif
  endtask

  function automatic logic [AW-1:0] randAddr();
    logic [11:0] ln;
    ln = 12'h100 + 12'($urandom_range(0, 2));
    return {ln, 4'($urandom_range(0, 15))};
  endfunction

  initial begin
    reset = 1'b1;
    cpuRequest = 1'b0; cpuAddress = '0; cpuDone = 1'b0;
    snoopRequest = '0; snoopAddress = '0; snoopDone = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset_cpuGrant", 32'(cpuGrant), 32'd0);
    check("reset_snoopGrant", 32'(snoopGrant), 32'd0);

    // single snoop grant/release
    snoopRequest = 2'b01; snoopAddress[15:0] = 16'h1230;
    step();
    check("snoop0_grant", 32'(snoopGrant), 32'd1);
    snoopRequest = '0;
    step();
    snoopDone = 2'b01;
    step();
    check("snoop0_release", 32'(snoopGrant), 32'd0);
    snoopDone = '0;
    step();

    // CPU owns line, same-line snoop waits for cpuDone
    cpuRequest = 1'b1; cpuAddress = 16'h1230;
    step(); step();
    check("cpu_own", 32'(cpuGrant), 32'd1);
    cpuRequest = 1'b0;
    snoopRequest = 2'b01; snoopAddress[15:0] = 16'h1238;
    step(); step(); step();
    check("snoop_blocked", 32'(snoopGrant), 32'd0);
`ifdef LOCK_STATS_EN
    check("conflict_3", 32'(conflictCount), 32'd3);
`endif
    cpuDone = 1'b1;
    step();
    check("handoff_snoop", 32'(snoopGrant), 32'd1);
    check("handoff_cpu", 32'(cpuGrant), 32'd0);
    cpuDone = 1'b0; snoopRequest = '0;
    step();
    snoopDone = 2'b01;
    step();
    snoopDone = '0;
    step();

    // different lines run concurrently
    cpuRequest = 1'b1; cpuAddress = 16'h1230;
    snoopRequest = 2'b10; snoopAddress[31:16] = 16'h4560;
    step(); step();
    check("conc_cpu", 32'(cpuGrant), 32'd1);
    check("conc_snoop", 32'(snoopGrant), 32'd2);
    cpuRequest = 1'b0; snoopRequest = '0;
    cpuDone = 1'b1; snoopDone = 2'b10;
    step();
    cpuDone = 1'b0; snoopDone = '0;
    step();

    // simultaneous same-line request: snoop wins
    cpuRequest = 1'b1; cpuAddress = 16'h2000;
    snoopRequest = 2'b01; snoopAddress[15:0] = 16'h2000;
    step();
    check("tie_snoop", 32'(snoopGrant), 32'd1);
    snoopRequest = '0;
    step(); step();
    check("tie_cpu_wait", 32'(cpuGrant), 32'd0);
    snoopDone = 2'b01;
    step();
    check("tie_cpu_still", 32'(cpuGrant), 32'd0);
    snoopDone = '0;
    step();
    check("tie_cpu_late", 32'(cpuGrant), 32'd1);
    cpuRequest = 1'b0; cpuDone = 1'b1;
    step();
    cpuDone = 1'b0;
    step();

    // round-robin alternation from a fresh pointer
    reset = 1'b1;
    step();
    reset = 1'b0;
    snoopRequest = 2'b11;
    snoopAddress = {16'h5000, 16'h3000};
    for (int k = 0; k < 3; k++) begin
      step();
      check("rr_grant", 32'(snoopGrant), (k % 2) ? 32'd2 : 32'd1);
      snoopDone = (k % 2) ? 2'b10 : 2'b01;
      step();
      snoopDone = '0;
    end
    snoopRequest = '0;
    step();

    // reset mid-transaction, then re-arbitrate from channel 0
    cpuRequest = 1'b1; cpuAddress = 16'h1230;
    snoopRequest = 2'b11;
    snoopAddress = {16'h9990, 16'h7770};
    step();
    check("pre_rst_snoop", 32'(snoopGrant), 32'd2);
    step();
    check("pre_rst_cpu", 32'(cpuGrant), 32'd1);
    reset = 1'b1;
    step();
    check("rst_cpu", 32'(cpuGrant), 32'd0);
    check("rst_snoop", 32'(snoopGrant), 32'd0);
`ifdef LOCK_STATS_EN
    check("rst_count", 32'(conflictCount), 32'd0);
`endif
    reset = 1'b0;
    step();
    check("post_rst_rr", 32'(snoopGrant), 32'd1);
    step();
    cpuRequest = 1'b0; snoopRequest = '0;
    cpuDone = 1'b1; snoopDone = 2'b01;
    step();
    cpuDone = 1'b0; snoopDone = '0;
    step();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (cpuRequest && mCpuGrant) cpuRequest = 1'b0;
      else if (!cpuRequest && mCpu == 0 && $urandom_range(0, 3) == 0) begin
        cpuRequest = 1'b1;
        cpuAddress = randAddr();
      end
      cpuDone = (mCpuGrant && $urandom_range(0, 2) == 0)
                || $urandom_range(0, 15) == 0;
      for (int i = 0; i < NP; i++) begin
        if (snoopRequest[i] && mSnoopGrant[i]) snoopRequest[i] = 1'b0;
        else if (!snoopRequest[i] && !mSnoopGrant[i]
                 && $urandom_range(0, 2) == 0) begin
          snoopRequest[i] = 1'b1;
          snoopAddress[i*AW +: AW] = randAddr();
        end
        snoopDone[i] = (mSnoopGrant[i] && $urandom_range(0, 2) == 0)
                       || $urandom_range(0, 15) == 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
